rd_bus_arbiter: RTL and testbench

- Shares the single memory read bus between the ICache and the DCache.
- Each cache keeps its existing read-bus handshake (`rrdy`/`ren`/`raddr`/`rvalid`/`rdata`) and connects to its own master port. The arbiter connects to the bus-side slave.
- Latches each master's one-cycle request, issues one block read at a time, and routes the response back to the owning master.

---
 rtl/rd_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_rd_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_bus_arbiter.sv
// Read-bus arbiter: shares one block-read bus between the ICache and DCache.
// Define ARB_RR_EN for round-robin tie-breaking; default build uses fixed DCache priority.
module rd_bus_arbiter #(
    parameter int BLK_LEN  = 4,
    parameter int BLK_SIZE = BLK_LEN * 32
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,

    output logic                ic_rrdy,
    input  logic [3:0]          ic_ren,
    input  logic [31:0]         ic_raddr,
    output logic                ic_rvalid,
    output logic [BLK_SIZE-1:0] ic_rdata,

    output logic                dc_rrdy,
    input  logic [3:0]          dc_ren,
    input  logic [31:0]         dc_raddr,
    output logic                dc_rvalid,
    output logic [BLK_SIZE-1:0] dc_rdata,

    input  logic                bus_rrdy,
    output logic [3:0]          bus_ren,
    output logic [31:0]         bus_raddr,
    input  logic                bus_rvalid,
    input  logic [BLK_SIZE-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    state_t      state;
    state_t      state_nx;
    owner_t      owner;
    owner_t      last_owner;
    owner_t      winner;

    logic        ic_pend;
    logic        dc_pend;
    logic [3:0]  ic_ren_q;
    logic [3:0]  dc_ren_q;
    logic [31:0] ic_addr_q;
    logic [31:0] dc_addr_q;

    logic        ic_cap;
    logic        dc_cap;
    logic        done;
    logic        ic_done;
    logic        dc_done;
    logic        grant;

    assign ic_rrdy = ~ic_pend;
    assign dc_rrdy = ~dc_pend;

    // A request is only accepted into an empty slot; a busy slot ignores ren.
    assign ic_cap  = ic_rrdy & (ic_ren != 4'd0);
    assign dc_cap  = dc_rrdy & (dc_ren != 4'd0);

    // A bus response outside IDLE completes the transaction of the current owner.
    assign done    = bus_rvalid & (state != IDLE);
    assign ic_done = done & (owner == OWN_IC);
    assign dc_done = done & (owner == OWN_DC);

    // Grant looks only at registered slots, so capture and grant never share an edge.
    assign grant   = (state == IDLE) & bus_rrdy & (ic_pend | dc_pend);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        // NOTE: the latched address/ren are reset as well; they are a few flops,
        // not a memory, and a clean reset keeps them out of X-propagation.
        if (!cpu_rst) begin
            ic_pend   <= 1'b0;
            ic_ren_q  <= 4'd0;
            ic_addr_q <= 32'd0;
        end else if (ic_cap) begin
            ic_pend   <= 1'b1;
            ic_ren_q  <= ic_ren;
            ic_addr_q <= ic_raddr;
        end else if (ic_done) begin
            ic_pend   <= 1'b0;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            dc_pend   <= 1'b0;
            dc_ren_q  <= 4'd0;
            dc_addr_q <= 32'd0;
        end else if (dc_cap) begin
            dc_pend   <= 1'b1;
            dc_ren_q  <= dc_ren;
            dc_addr_q <= dc_raddr;
        end else if (dc_done) begin
            dc_pend   <= 1'b0;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        winner = OWN_IC;
        if (ic_pend && dc_pend) begin
`ifdef ARB_RR_EN
            winner = (last_owner == OWN_DC) ? OWN_IC : OWN_DC;
`else
            winner = OWN_DC;
`endif
        end else if (dc_pend) begin
            winner = OWN_DC;
        end
    end

`ifndef ARB_RR_EN
    // last_owner is still tracked in fixed-priority builds for debug visibility.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = REQ;
            REQ:     state_nx = bus_rvalid ? IDLE : WAIT;
            WAIT:    if (bus_rvalid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // bus_ren is a one-cycle strobe loaded on grant; bus_raddr holds until the next grant.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            bus_ren    <= 4'd0;
            bus_raddr  <= 32'd0;
            owner      <= OWN_IC;
            last_owner <= OWN_IC;
        end else begin
            bus_ren <= 4'd0;
            if (grant) begin
                owner     <= winner;
                bus_ren   <= (winner == OWN_DC) ? dc_ren_q  : ic_ren_q;
                bus_raddr <= (winner == OWN_DC) ? dc_addr_q : ic_addr_q;
            end
            if (done) begin
                last_owner <= owner;
            end
        end
    end

    assign ic_rvalid = bus_rvalid & (state != IDLE) & (owner == OWN_IC);
    assign dc_rvalid = bus_rvalid & (state != IDLE) & (owner == OWN_DC);
    assign ic_rdata  = bus_rdata;
    assign dc_rdata  = bus_rdata;

endmodule

// File: tb/tb_rd_bus_arbiter.sv
// Self-checking bench for rd_bus_arbiter: per-cycle vector table plus hand sequences.
// Expectations for the tie-break case follow ARB_RR_EN when it is defined.
module tb_rd_bus_arbiter;

    localparam int BLK_LEN  = 4;
    localparam int BLK_SIZE = BLK_LEN * 32;

    logic                cpu_clk;
    logic                cpu_rst;
    logic                ic_rrdy;
    logic [3:0]          ic_ren;
    logic [31:0]         ic_raddr;
    logic                ic_rvalid;
    logic [BLK_SIZE-1:0] ic_rdata;
    logic                dc_rrdy;
    logic [3:0]          dc_ren;
    logic [31:0]         dc_raddr;
    logic                dc_rvalid;
    logic [BLK_SIZE-1:0] dc_rdata;
    logic                bus_rrdy;
    logic [3:0]          bus_ren;
    logic [31:0]         bus_raddr;
    logic                bus_rvalid;
    logic [BLK_SIZE-1:0] bus_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    rd_bus_arbiter #(.BLK_LEN(BLK_LEN)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .ic_rrdy    (ic_rrdy),
        .ic_ren     (ic_ren),
        .ic_raddr   (ic_raddr),
        .ic_rvalid  (ic_rvalid),
        .ic_rdata   (ic_rdata),
        .dc_rrdy    (dc_rrdy),
        .dc_ren     (dc_ren),
        .dc_raddr   (dc_raddr),
        .dc_rvalid  (dc_rvalid),
        .dc_rdata   (dc_rdata),
        .bus_rrdy   (bus_rrdy),
        .bus_ren    (bus_ren),
        .bus_raddr  (bus_raddr),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [3:0]  ic_ren;
        logic [31:0] ic_raddr;
        logic [3:0]  dc_ren;
        logic [31:0] dc_raddr;
        logic        bus_rrdy;
        logic        bus_rvalid;
        logic [31:0] rword;
        logic        e_ic_rrdy;
        logic        e_dc_rrdy;
        logic [3:0]  e_bus_ren;
        logic [31:0] e_bus_raddr;
        logic        e_ic_rvalid;
        logic        e_dc_rvalid;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [BLK_SIZE-1:0] act,
                         input logic [BLK_SIZE-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] icr, input logic [31:0] ica,
                       input logic [3:0] dcr, input logic [31:0] dca,
                       input logic brdy, input logic bval, input logic [31:0] w,
                       input logic eir, input logic edr, input logic [3:0] eren,
                       input logic [31:0] eaddr, input logic eiv, input logic edv);
        vec_t v;
        v.ic_ren = icr;   v.ic_raddr = ica;  v.dc_ren = dcr;   v.dc_raddr = dca;
        v.bus_rrdy = brdy; v.bus_rvalid = bval; v.rword = w;
        v.e_ic_rrdy = eir; v.e_dc_rrdy = edr; v.e_bus_ren = eren;
        v.e_bus_raddr = eaddr; v.e_ic_rvalid = eiv; v.e_dc_rvalid = edv;
        vecs.push_back(v);
    endtask

    // Waits for a bus request, checks its address, answers it and checks routing.
    task automatic bus_txn(input string tag, input logic [31:0] exp_addr,
                           input logic exp_dc, input logic [31:0] w);
        logic found = 1'b0;
        int   n = 0;
        while (!found && n < 40) begin
            @(negedge cpu_clk); #1;
            if (bus_ren != 4'd0) found = 1'b1;
            n++;
        end
        check({tag, " req_seen"}, found, 1'b1);
        check({tag, " bus_raddr"}, bus_raddr, exp_addr);
        check({tag, " bus_ren"}, bus_ren, 4'hF);
        @(negedge cpu_clk);
        bus_rvalid = 1'b1;
        bus_rdata  = {4{w}};
        #1;
        check({tag, " ren_one_cycle"}, bus_ren, 4'd0);
        check({tag, " ic_rvalid"}, ic_rvalid, !exp_dc);
        check({tag, " dc_rvalid"}, dc_rvalid, exp_dc);
        check({tag, " rdata"}, exp_dc ? dc_rdata : ic_rdata, {4{w}});
        @(negedge cpu_clk);
        bus_rvalid = 1'b0;
    endtask

    task automatic tie(input string tag, input logic first_dc);
        @(negedge cpu_clk);
        ic_ren = 4'hF; ic_raddr = 32'h100;
        dc_ren = 4'hF; dc_raddr = 32'h200;
        @(negedge cpu_clk);
        ic_ren = 4'h0; dc_ren = 4'h0;
        bus_txn({tag, "_1st"}, first_dc ? 32'h200 : 32'h100, first_dc, 32'h1111_0001);
        bus_txn({tag, "_2nd"}, first_dc ? 32'h100 : 32'h200, !first_dc, 32'h2222_0002);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ic_ren = 0; ic_raddr = 0; dc_ren = 0; dc_raddr = 0;
        bus_rrdy = 1'b1; bus_rvalid = 1'b0; bus_rdata = '0;
        cpu_rst = 1'b1;
        #1 cpu_rst = 1'b0;
        repeat (2) @(negedge cpu_clk);
        #1;
        check("rst ic_rrdy", ic_rrdy, 1'b1);
        check("rst dc_rrdy", dc_rrdy, 1'b1);
        check("rst bus_ren", bus_ren, 4'd0);
        check("rst bus_raddr", bus_raddr, 32'd0);
        check("rst ic_rvalid", ic_rvalid, 1'b0);
        check("rst dc_rvalid", dc_rvalid, 1'b0);
        cpu_rst = 1'b1;

        // ICache alone, then a stray bus_rvalid in IDLE.
        add(4'hF, 32'h1230, 4'h0, 32'h0, 1, 0, 32'h0,          1, 1, 4'h0, 32'h0,    0, 0);
        add(4'h0, 32'h1230, 4'h0, 32'h0, 1, 0, 32'h0,          0, 1, 4'h0, 32'h0,    0, 0);
        add(4'h0, 32'h1230, 4'h0, 32'h0, 1, 0, 32'h0,          0, 1, 4'hF, 32'h1230, 0, 0);
        add(4'h0, 32'h1230, 4'h0, 32'h0, 1, 0, 32'h0,          0, 1, 4'h0, 32'h1230, 0, 0);
        add(4'h0, 32'h1230, 4'h0, 32'h0, 1, 1, 32'hCAFE_DEAD,  0, 1, 4'h0, 32'h1230, 1, 0);
        add(4'h0, 32'h1230, 4'h0, 32'h0, 1, 0, 32'h0,          1, 1, 4'h0, 32'h1230, 0, 0);
        add(4'h0, 32'h1230, 4'h0, 32'h0, 1, 1, 32'h5555_5555,  1, 1, 4'h0, 32'h1230, 0, 0);
        // Simultaneous requests with last_owner=IC: DCache first in either mode.
        // Second row re-issues dc_ren to a busy slot; it must be ignored.
        add(4'hF, 32'h100,  4'hF, 32'h200, 1, 0, 32'h0,        1, 1, 4'h0, 32'h1230, 0, 0);
        add(4'h0, 32'h100,  4'hF, 32'h300, 1, 0, 32'h0,        0, 0, 4'h0, 32'h1230, 0, 0);
        add(4'h0, 32'h100,  4'h0, 32'h300, 1, 0, 32'h0,        0, 0, 4'hF, 32'h200,  0, 0);
        add(4'h0, 32'h100,  4'h0, 32'h300, 1, 1, 32'h0000_AAAA, 0, 0, 4'h0, 32'h200, 0, 1);
        add(4'h0, 32'h100,  4'h0, 32'h300, 1, 0, 32'h0,        0, 1, 4'h0, 32'h200,  0, 0);
        add(4'h0, 32'h100,  4'h0, 32'h300, 1, 0, 32'h0,        0, 1, 4'hF, 32'h100,  0, 0);
        add(4'h0, 32'h100,  4'h0, 32'h300, 1, 1, 32'h0000_BBBB, 0, 1, 4'h0, 32'h100, 1, 0);
        add(4'h0, 32'h100,  4'h0, 32'h300, 1, 0, 32'h0,        1, 1, 4'h0, 32'h100,  0, 0);
        add(4'h0, 32'h100,  4'h0, 32'h300, 1, 0, 32'h0,        1, 1, 4'h0, 32'h100,  0, 0);

        foreach (vecs[i]) begin
            @(negedge cpu_clk);
            ic_ren = vecs[i].ic_ren;   ic_raddr = vecs[i].ic_raddr;
            dc_ren = vecs[i].dc_ren;   dc_raddr = vecs[i].dc_raddr;
            bus_rrdy = vecs[i].bus_rrdy; bus_rvalid = vecs[i].bus_rvalid;
            bus_rdata = {4{vecs[i].rword}};
            #1;
            check($sformatf("v%0d ic_rrdy", i),   ic_rrdy,   vecs[i].e_ic_rrdy);
            check($sformatf("v%0d dc_rrdy", i),   dc_rrdy,   vecs[i].e_dc_rrdy);
            check($sformatf("v%0d bus_ren", i),   bus_ren,   vecs[i].e_bus_ren);
            check($sformatf("v%0d bus_raddr", i), bus_raddr, vecs[i].e_bus_raddr);
            check($sformatf("v%0d ic_rvalid", i), ic_rvalid, vecs[i].e_ic_rvalid);
            check($sformatf("v%0d dc_rvalid", i), dc_rvalid, vecs[i].e_dc_rvalid);
            if (vecs[i].e_ic_rvalid)
                check($sformatf("v%0d ic_rdata", i), ic_rdata, {4{vecs[i].rword}});
            if (vecs[i].e_dc_rvalid)
                check($sformatf("v%0d dc_rdata", i), dc_rdata, {4{vecs[i].rword}});
        end
        @(negedge cpu_clk);
        ic_ren = 0; dc_ren = 0; bus_rvalid = 1'b0;

        // bus_rrdy low for 10 cycles with ICache pending.
        bus_rrdy = 1'b0;
        ic_ren = 4'hF; ic_raddr = 32'h400;
        @(negedge cpu_clk);
        ic_ren = 4'h0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check($sformatf("stall%0d bus_ren", c), bus_ren, 4'd0);
            check($sformatf("stall%0d ic_rrdy", c), ic_rrdy, 1'b0);
            @(negedge cpu_clk);
        end
        bus_rrdy = 1'b1;
        @(negedge cpu_clk); #1;
        check("stall_release bus_ren", bus_ren, 4'hF);
        check("stall_release bus_raddr", bus_raddr, 32'h400);
        @(negedge cpu_clk);
        bus_rvalid = 1'b1; bus_rdata = {4{32'h0000_0400}};
        #1;
        check("stall_release ic_rvalid", ic_rvalid, 1'b1);
        @(negedge cpu_clk);
        bus_rvalid = 1'b0;

        // Three ties with last_owner=IC each time: D,I,D,I,D,I.
        for (int r = 0; r < 3; r++) tie($sformatf("rep%0d", r), 1'b1);

        // Reset pulsed during WAIT with DCache owning the bus.
        @(negedge cpu_clk);
        dc_ren = 4'hF; dc_raddr = 32'h500;
        @(negedge cpu_clk);
        dc_ren = 4'h0;
        @(negedge cpu_clk); #1;
        check("rstmid granted", bus_ren, 4'hF);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        #1;
        check("rstmid bus_ren", bus_ren, 4'd0);
        check("rstmid bus_raddr", bus_raddr, 32'd0);
        check("rstmid ic_rrdy", ic_rrdy, 1'b1);
        check("rstmid dc_rrdy", dc_rrdy, 1'b1);
        #2 cpu_rst = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = {4{32'hDEAD_0500}};
        #1;
        check("late_rvalid dc_rvalid", dc_rvalid, 1'b0);
        check("late_rvalid ic_rvalid", ic_rvalid, 1'b0);
        @(negedge cpu_clk);
        bus_rvalid = 1'b0;
        #1;
        check("post_rst bus_ren", bus_ren, 4'd0);
        check("post_rst ic_rrdy", ic_rrdy, 1'b1);
        check("post_rst dc_rrdy", dc_rrdy, 1'b1);

        // DCache alone sets last_owner=DC; the following tie separates the two modes.
        @(negedge cpu_clk);
        dc_ren = 4'hF; dc_raddr = 32'h600;
        @(negedge cpu_clk);
        dc_ren = 4'h0;
        bus_txn("dc_alone", 32'h600, 1'b1, 32'h0000_0600);
`ifdef ARB_RR_EN
        tie("rr_tie", 1'b0);
`else
        tie("fixed_tie", 1'b1);
`endif

        repeat (2) @(negedge cpu_clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
